// File: rtl/lab_pkg.sv
// Shared definitions for the lab datapath primitives: operation encodings
// and the shift-counter width helper.
package lab_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // Counter must hold 0..WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_next.sv
// Combinational next-state mux for univ_shift_reg. It also classifies the
// selected operation so the top can steer the shift counter.
module shift_next
    import lab_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             is_shift,
    output logic             is_restart
);

    logic [WIDTH-1:0] shl, shr, rotl, rotr;

    // A single-bit register has no neighbours: shifts take the serial input
    // and rotates collapse to hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl  = sin_r;
            assign shr  = sin_l;
            assign rotl = q;
            assign rotr = q;
        end else begin : g_wn
            assign shl  = {q[WIDTH-2:0], sin_r};
            assign shr  = {sin_l, q[WIDTH-1:1]};
            assign rotl = {q[WIDTH-2:0], q[WIDTH-1]};
            assign rotr = {q[0], q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_next     = q;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (mode)
            MODE_LOAD: begin q_next = d;       is_restart = 1'b1; end
            MODE_SHL:  begin q_next = shl;     is_shift   = 1'b1; end
            MODE_SHR:  begin q_next = shr;     is_shift   = 1'b1; end
            MODE_ROTL: begin q_next = rotl;    is_shift   = 1'b1; end
            MODE_ROTR: begin q_next = rotr;    is_shift   = 1'b1; end
            MODE_CLR:  begin q_next = '0;      is_restart = 1'b1; end
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with a per-word
// shift counter and a one-cycle done pulse on word completion.
module univ_shift_reg
    import lab_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_next;
    logic             is_shift;
    logic             is_restart;

    shift_next #(.WIDTH(WIDTH)) u_next (
        .q          (q),
        .d          (d),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .mode       (mode),
        .q_next     (q_next),
        .is_shift   (is_shift),
        .is_restart (is_restart)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                q <= q_next;
                if (is_restart) begin
                    shift_cnt <= '0;
                end else if (is_shift) begin
                    // Wrap on the WIDTH-th shift instead of ever reaching WIDTH.
                    if (shift_cnt == CW'(WIDTH - 1)) begin
                        shift_cnt <= '0;
                        done      <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit instance with a non-zero reset
// value and a 1-bit instance, sharing one clock.
module tb_univ_shift_reg;
    import lab_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       res, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [7:0] d, q;
    logic       sout_msb, sout_lsb, done;
    logic [3:0] shift_cnt;

    // 1-bit instance
    logic       res1, en1, sin_r1, sin_l1;
    logic [2:0] mode1;
    logic [0:0] d1, q1;
    logic       sout_msb1, sout_lsb1, done1;
    logic [0:0] shift_cnt1;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
        .clk(clk), .res(res), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_msb(sout_msb),
        .sout_lsb(sout_lsb), .shift_cnt(shift_cnt), .done(done)
    );

    univ_shift_reg #(.WIDTH(1)) u1 (
        .clk(clk), .res(res1), .en(en1), .mode(mode1), .d(d1),
        .sin_r(sin_r1), .sin_l(sin_l1), .q(q1), .sout_msb(sout_msb1),
        .sout_lsb(sout_lsb1), .shift_cnt(shift_cnt1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        res = 1'b0; en = 1'b1; mode = MODE_LOAD; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
        res1 = 1'b0; en1 = 1'b0; mode1 = MODE_HOLD; d1 = 1'b0; sin_r1 = 1'b0; sin_l1 = 1'b0;

        // Reset wins over en/LOAD
        step(); step();
        chk("rst_q", q, 8'hA5);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_q1", q1, 0);

        // Load then shift left
        res = 1'b1; mode = MODE_LOAD; d = 8'h81;
        step();
        chk("load_q", q, 8'h81);
        mode = MODE_SHL; sin_r = 1'b1;
        step(); chk("shl1_q", q, 8'h03);
        step(); step();
        chk("shl3_q", q, 8'h0F);
        chk("shl3_cnt", shift_cnt, 3);
        chk("shl3_msb", sout_msb, 0);

        // Serialize C3 via ROTR
        mode = MODE_LOAD; d = 8'hC3;
        step();
        chk("ser_cnt0", shift_cnt, 0);
        pat = 8'hC3;
        mode = MODE_ROTR;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_lsb%0d", i), sout_lsb, pat[i]);
            chk($sformatf("ser_nodone%0d", i), done, 0);
            step();
        end
        chk("ser_q", q, 8'hC3);
        chk("ser_done", done, 1);
        chk("ser_cnt", shift_cnt, 0);
        mode = MODE_HOLD;
        step();
        chk("ser_done_1cyc", done, 0);

        // Enable gating and reserved mode
        mode = MODE_LOAD; d = 8'h3C;
        step();
        en = 1'b0; mode = MODE_SHL;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_done", done, 0);
        end
        chk("gate_q", q, 8'h3C);
        en = 1'b1; mode = MODE_RSVD;
        step(); step();
        chk("rsvd_q", q, 8'h3C);
        chk("rsvd_cnt", shift_cnt, 0);
        chk("rsvd_done", done, 0);

        // ROTL wraps MSB into LSB
        mode = MODE_LOAD; d = 8'h81;
        step();
        mode = MODE_ROTL;
        step();
        chk("rotl_q", q, 8'h03);
        chk("rotl_cnt", shift_cnt, 1);

        // 7 SHR then LOAD on the would-be completion edge
        mode = MODE_LOAD; d = 8'h00;
        step();
        mode = MODE_SHR; sin_l = 1'b1;
        repeat (7) step();
        chk("shr7_q", q, 8'hFE);
        chk("shr7_cnt", shift_cnt, 7);
        mode = MODE_LOAD; d = 8'h11;
        step();
        chk("ldcol_q", q, 8'h11);
        chk("ldcol_cnt", shift_cnt, 0);
        chk("ldcol_done", done, 0);
        mode = MODE_HOLD;
        step();
        chk("ldcol_done2", done, 0);

        // 7 SHR then reset on the 8th edge
        mode = MODE_SHR;
        repeat (7) step();
        chk("rst7_cnt", shift_cnt, 7);
        res = 1'b0;
        step();
        chk("rstcol_q", q, 8'hA5);
        chk("rstcol_cnt", shift_cnt, 0);
        chk("rstcol_done", done, 0);
        res = 1'b1; mode = MODE_HOLD;
        step();
        chk("rstcol_done2", done, 0);

        // CLR goes to zero, not to the reset value
        mode = MODE_CLR;
        step();
        chk("clr_q", q, 8'h00);
        chk("clr_cnt", shift_cnt, 0);

        // WIDTH=1: every shift completes a word
        res1 = 1'b1; en1 = 1'b1; mode1 = MODE_SHL; sin_r1 = 1'b1;
        step();
        chk("w1_shl_q", q1, 1);
        chk("w1_shl_done", done1, 1);
        chk("w1_shl_cnt", shift_cnt1, 0);
        step();
        chk("w1_shl_done2", done1, 1);
        mode1 = MODE_ROTL;
        step();
        chk("w1_rotl_q", q1, 1);
        chk("w1_rotl_done", done1, 1);
        mode1 = MODE_SHR; sin_l1 = 1'b0;
        step();
        chk("w1_shr_q", q1, 0);
        chk("w1_shr_msb", sout_msb1, 0);
        mode1 = MODE_HOLD;
        step();
        chk("w1_hold_done", done1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
